md_sched: RTL and testbench



---
 rtl/md_sched_pkg.sv | 14 +
 rtl/md_core.sv | 37 +++
 rtl/md_sched.sv | 99 +++++++++
 tb/tb_md_sched.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// md_sched_pkg: shared MDOp encodings and scheduler state type for the multiply/divide unit
package md_sched_pkg;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;
endpackage

// File: rtl/md_core.sv
// md_core: combinational 32x32 multiply (and divide when MD_DIV_EN is defined) producing {HI,LO}
module md_core
  import md_sched_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  md_op_e      i_op,
  output logic [63:0] o_res,
  output logic        o_we
);
  logic [63:0] w_mul_s;
  logic [63:0] w_mul_u;
  assign w_mul_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_mul_u = {32'b0, i_a} * {32'b0, i_b};
`ifdef MD_DIV_EN
  logic [31:0] w_den;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;
  logic        w_is_div;
  // a zero divisor is swapped for 1 so the divider never sees it; the result is discarded anyway
  assign w_den    = (i_b == 32'b0) ? 32'd1 : i_b;
  assign w_quo_s  = $signed(i_a) / $signed(w_den);
  assign w_rem_s  = $signed(i_a) % $signed(w_den);
  assign w_quo_u  = i_a / w_den;
  assign w_rem_u  = i_a % w_den;
  assign w_is_div = (i_op == MD_DIV) || (i_op == MD_DIVU);
  assign o_res    = (i_op == MD_DIV)   ? {w_rem_s, w_quo_s} :
                    (i_op == MD_DIVU)  ? {w_rem_u, w_quo_u} :
                    (i_op == MD_MULTU) ? w_mul_u : w_mul_s;
  assign o_we     = !(w_is_div && (i_b == 32'b0));
`else
  assign o_res    = (i_op == MD_MULTU) ? w_mul_u : w_mul_s;
  assign o_we     = 1'b1;
`endif
endmodule

// File: rtl/md_sched.sv
// md_sched: multicycle HI/LO scheduler with stall request; div/divu exist only when MD_DIV_EN is defined
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  input  logic        D_IsMD,
  output logic        Busy,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = $clog2((DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES) + 1;
  md_state_e   r_state;
  md_state_e   w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  md_op_e      r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_open;
  logic        w_launch;
  logic        w_mt_hi;
  logic        w_mt_lo;
  logic        w_commit;
  logic [63:0] w_res;
  logic        w_we;
  md_core u_core (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_res(w_res),
    .o_we (w_we)
  );
  // decode the E-stage op and pick the next scheduler state
  always_comb begin
    w_is_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
`ifdef MD_DIV_EN
    w_is_div = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
`else
    w_is_div = 1'b0;
`endif
    w_open   = (r_state != S_BUSY);
    w_launch = Start && w_open && (w_is_mul || w_is_div);
    w_mt_hi  = Start && w_open && (MDOp == MD_MTHI);
    w_mt_lo  = Start && w_open && (MDOp == MD_MTLO);
    w_commit = (r_state == S_BUSY) && (r_cnt == '0);
    w_next   = w_launch ? S_BUSY :
               w_commit ? S_DONE :
               (r_state == S_BUSY) ? S_BUSY : S_IDLE;
  end
  // scheduler state register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // operand latches, latency counter and HI/LO updates
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= MD_NONE;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_launch) begin
        r_a   <= Data1;
        r_b   <= Data2;
        r_op  <= md_op_e'(MDOp);
        r_cnt <= w_is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_commit && w_we) begin
        r_hi <= w_res[63:32];
        r_lo <= w_res[31:0];
      end
      if (w_mt_hi) r_hi <= Data1;
      if (w_mt_lo) r_lo <= Data1;
    end
  end
  assign Busy  = (r_state == S_BUSY);
  assign Done  = (r_state == S_DONE);
  assign Stall = D_IsMD && (Busy || (Start && (w_is_mul || w_is_div)));
  assign HI    = r_hi;
  assign LO    = r_lo;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched (div cases depend on MD_DIV_EN)
module tb_md_sched;
  import md_sched_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        d_ismd = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  int          n_pass = 0;
  int          n_tot = 0;
  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (clk),
    .Reset (rst),
    .Start (start),
    .MDOp  (op),
    .Data1 (d1),
    .Data2 (d2),
    .D_IsMD(d_ismd),
    .Busy  (busy),
    .Stall (stall),
    .Done  (done),
    .HI    (hi),
    .LO    (lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) assert (!(start && busy)) else $error("start issued while busy");
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int n,
                     input logic s0, input logic [31:0] eh, input logic [31:0] el, input string tag);
    logic [31:0] oh;
    logic [31:0] ol;
    oh = hi;
    ol = lo;
    start = 1'b1;
    op = o;
    d1 = a;
    d2 = b;
    #1;
    chk({tag, " stall c0"}, 64'(stall), 64'(s0));
    tick;
    start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk($sformatf("%s busy/done c%0d", tag, i), {62'b0, busy, done}, 64'b10);
      chk($sformatf("%s hilo hold c%0d", tag, i), {hi, lo}, {oh, ol});
      chk($sformatf("%s stall c%0d", tag, i), 64'(stall), 64'(d_ismd));
    end
    @(negedge clk);
    chk({tag, " busy/done end"}, {62'b0, busy, done}, 64'b01);
    chk({tag, " hilo end"}, {hi, lo}, {eh, el});
    chk({tag, " stall end"}, 64'(stall), 64'b0);
  endtask
  task automatic mt(input logic [2:0] o, input logic [31:0] v, input logic [31:0] eh,
                    input logic [31:0] el, input string tag);
    start = 1'b1;
    op = o;
    d1 = v;
    d2 = 32'h5555_AAAA;
    #1;
    chk({tag, " stall"}, 64'(stall), 64'b0);
    tick;
    start = 1'b0;
    @(negedge clk);
    chk({tag, " busy/done"}, {62'b0, busy, done}, 64'b00);
    chk({tag, " hilo"}, {hi, lo}, {eh, el});
  endtask
  initial begin
    logic [2:0] abort_op;
    repeat (2) tick;
    rst = 1'b0;
    d_ismd = 1'b1;
    @(negedge clk);
    chk("reset busy/done", {62'b0, busy, done}, 64'b00);
    chk("reset hilo", {hi, lo}, 64'b0);
    chk("reset stall", 64'(stall), 64'b0);
    run(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    d_ismd = 1'b0;
    run(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    @(negedge clk);
    chk("idle after done", {62'b0, busy, done}, 64'b00);
    d_ismd = 1'b1;
    mt(MD_MTHI, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFE, "mthi");
    mt(MD_MTLO, 32'hCAFE_F00D, 32'h1234_5678, 32'hCAFE_F00D, "mtlo");
    mt(MD_RSVD, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, "undef7");
    mt(MD_NONE, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, "undef0");
`ifdef MD_DIV_EN
    run(MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, "div");
    run(MD_DIVU, 32'd100, 32'd7, 10, 1'b1, 32'h0000_0002, 32'h0000_000E, "divu");
    run(MD_DIV, 32'd5, 32'd0, 10, 1'b1, 32'h0000_0002, 32'h0000_000E, "div0");
    mt(MD_MTHI, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_000E, "mthi in done");
    abort_op = MD_DIV;
`else
    mt(MD_DIV, 32'd7, 32'h1234_5678, 32'hCAFE_F00D, "div off");
    mt(MD_DIVU, 32'd100, 32'h1234_5678, 32'hCAFE_F00D, "divu off");
    abort_op = MD_MULT;
`endif
    start = 1'b1;
    op = abort_op;
    d1 = 32'd7;
    d2 = 32'd3;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy c3", 64'(busy), 64'b1);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy/done c4", {62'b0, busy, done}, 64'b00);
    chk("abort hilo c4", {hi, lo}, 64'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("abort no done %0d", i), {62'b0, busy, done}, 64'b00);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
